// File: rtl/exec_stage.sv
// exec_stage: execute/writeback stage. Owns the 8x16 register file and the
// NZCV flag register, runs a single-cycle ALU and a serial 1-bit/cycle shifter.
module exec_stage #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          unary,
    input  logic          sgned,
    input  logic          imode,
    input  logic [3:0]    aluop,
    input  logic          setcc,
    input  logic [2:0]    rD,
    input  logic [2:0]    rA,
    input  logic [2:0]    rB,
    input  logic [3:0]    imm,
    input  logic          wben,
    output logic          wb_valid,
    output logic [2:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic [3:0]    flags,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int unsigned IW = 4;
    localparam int unsigned CW = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0010;
    localparam logic [3:0] OP_ASR = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_ROL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;

    logic [DW-1:0] regs [NREG];

    // Instruction in flight
    logic [3:0]    op_q;
    logic [2:0]    rd_q;
    logic          wben_q;
    logic          setcc_q;
    logic [DW-1:0] a_q;      // operand A, doubles as the shift accumulator
    logic [DW-1:0] b_q;
    logic [CW-1:0] cnt_q;

    logic          accept_c;
    logic          retire_c;
    logic          def_c;
    logic          wr_en_c;
    logic          flag_en_c;
    logic [DW-1:0] ext_c;
    logic [DW-1:0] rdata_a_c;
    logic [DW-1:0] rdata_b_c;
    logic [DW-1:0] opa_c;
    logic [DW-1:0] opb_c;
    logic [DW-1:0] shift_c;
    logic          sout_c;
    logic [DW:0]   sum_c;
    logic [DW-1:0] res_c;
    logic          c_c;
    logic          v_c;

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

    assign in_ready = (state != SHIFT);
    assign accept_c = in_valid && in_ready;
    assign dbg_data = regs[dbg_addr];

    // Retire happens at the end of EXEC or on the last shift step
    assign retire_c  = (state == EXEC) || ((state == SHIFT) && (cnt_q == CW'(1)));
    assign wr_en_c   = retire_c && def_c && wben_q;
    assign flag_en_c = retire_c && def_c && setcc_q;

    // Operand fetch with bypass of a same-edge register write
    always_comb begin
        ext_c     = sgned ? {{(DW-IW){imm[IW-1]}}, imm} : {{(DW-IW){1'b0}}, imm};
        rdata_a_c = (wr_en_c && (rd_q == rA)) ? res_c : regs[rA];
        rdata_b_c = (wr_en_c && (rd_q == rB)) ? res_c : regs[rB];
        opa_c     = unary ? '0 : rdata_a_c;
        opb_c     = imode ? ext_c : rdata_b_c;
    end

    // One-bit step of the serial shifter and the bit it pushes out
    always_comb begin
        shift_c = a_q;
        sout_c  = 1'b0;
        case (op_q)
            OP_SHL: begin
                shift_c = {a_q[DW-2:0], 1'b0};
                sout_c  = a_q[DW-1];
            end
            OP_ASR: begin
                shift_c = {a_q[DW-1], a_q[DW-1:1]};
                sout_c  = a_q[0];
            end
            OP_LSR: begin
                shift_c = {1'b0, a_q[DW-1:1]};
                sout_c  = a_q[0];
            end
            OP_ROL: begin
                shift_c = {a_q[DW-2:0], a_q[DW-1]};
                sout_c  = a_q[DW-1];
            end
            OP_ROR: begin
                shift_c = {a_q[0], a_q[DW-1:1]};
                sout_c  = a_q[0];
            end
            default: ;
        endcase
    end

    // Result and carry/overflow of the retiring instruction
    always_comb begin
        sum_c = '0;
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        def_c = 1'b1;
        if (state == SHIFT) begin
            res_c = shift_c;
            c_c   = sout_c;
        end else begin
            case (op_q)
                OP_ADD: begin
                    sum_c = {1'b0, a_q} + {1'b0, b_q};
                    res_c = sum_c[DW-1:0];
                    c_c   = sum_c[DW];
                    v_c   = (a_q[DW-1] == b_q[DW-1]) && (res_c[DW-1] != a_q[DW-1]);
                end
                OP_SUB: begin
                    sum_c = {1'b0, a_q} + {1'b0, ~b_q} + {{DW{1'b0}}, 1'b1};
                    res_c = sum_c[DW-1:0];
                    c_c   = sum_c[DW];
                    v_c   = (a_q[DW-1] != b_q[DW-1]) && (res_c[DW-1] != a_q[DW-1]);
                end
                OP_SHL, OP_ASR, OP_LSR, OP_ROL, OP_ROR: res_c = a_q;
                OP_AND: res_c = a_q & b_q;
                OP_OR:  res_c = a_q | b_q;
                OP_NOT: res_c = ~b_q;
                default: def_c = 1'b0;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE, EXEC: begin
                if (accept_c) begin
                    if (is_shift(aluop) && (opb_c[CW-1:0] != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = EXEC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Instruction capture and shift accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            rd_q    <= '0;
            wben_q  <= 1'b0;
            setcc_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else if (accept_c) begin
            op_q    <= aluop;
            rd_q    <= rD;
            wben_q  <= wben;
            setcc_q <= setcc;
            a_q     <= opa_c;
            b_q     <= opb_c;
            cnt_q   <= opb_c[CW-1:0];
        end else if (state == SHIFT) begin
            a_q   <= shift_c;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Register file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs[rd_q] <= res_c;
        end
    end

    // Writeback outputs and flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            flags    <= '0;
        end else begin
            wb_valid <= retire_c;
            if (retire_c) begin
                wb_rd   <= rd_q;
                wb_data <= res_c;
            end
            if (flag_en_c) begin
                flags <= {res_c[DW-1], (res_c == '0), c_c, v_c};
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: a reference model computes each result
// at issue time and the writeback monitor compares against a scoreboard queue.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        unary = 1'b0;
    logic        sgned = 1'b0;
    logic        imode = 1'b0;
    logic [3:0]  aluop = 4'h0;
    logic        setcc = 1'b0;
    logic [2:0]  rD = 3'd0;
    logic [2:0]  rA = 3'd0;
    logic [2:0]  rB = 3'd0;
    logic [3:0]  imm = 4'h0;
    logic        wben = 1'b0;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  flags;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic [15:0] regval;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [15:0] m_regs [8];
    logic [3:0]  m_flags;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    exec_stage dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .unary    (unary),
        .sgned    (sgned),
        .imode    (imode),
        .aluop    (aluop),
        .setcc    (setcc),
        .rD       (rD),
        .rA       (rA),
        .rB       (rB),
        .imm      (imm),
        .wben     (wben),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flags    (flags),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_flags = 4'h0;
    endtask

    // Drive one instruction, compute its expected outcome and queue it
    task automatic issue(input logic un, input logic sg, input logic im, input logic [3:0] op,
                         input logic sc, input logic [2:0] d, input logic [2:0] a,
                         input logic [2:0] b, input logic [3:0] i, input logic we);
        exp_t        e;
        logic [15:0] va, vb, r;
        logic        c, v, def;
        int          k, lat, n, ssum, usum;
        unary = un; sgned = sg; imode = im; aluop = op; setcc = sc;
        rD = d; rA = a; rB = b; imm = i; wben = we; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("accept_timeout", in_ready, 1);
        va  = un ? 16'h0 : m_regs[a];
        vb  = im ? (sg ? {{12{i[3]}}, i} : {12'h0, i}) : m_regs[b];
        k   = int'(vb[3:0]);
        lat = 1;
        c   = 1'b0;
        v   = 1'b0;
        def = 1'b1;
        r   = 16'h0;
        case (op)
            4'h0: begin
                usum = int'(va) + int'(vb);
                ssum = int'($signed(va)) + int'($signed(vb));
                r = 16'(usum);
                c = (usum > 65535);
                v = (ssum > 32767) || (ssum < -32768);
            end
            4'h1: begin
                ssum = int'($signed(va)) - int'($signed(vb));
                r = va - vb;
                c = (va >= vb);
                v = (ssum > 32767) || (ssum < -32768);
            end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                if (k == 0) begin
                    r = va;
                end else begin
                    lat = k;
                    case (op)
                        4'h2: begin r = va << k; c = va[16-k]; end
                        4'h3: begin r = 16'($signed(va) >>> k); c = va[k-1]; end
                        4'h4: begin r = va >> k; c = va[k-1]; end
                        4'h5: begin r = (va << k) | (va >> (16 - k)); c = r[0]; end
                        default: begin r = (va >> k) | (va << (16 - k)); c = r[15]; end
                    endcase
                end
            end
            4'h8: r = va & vb;
            4'h9: r = va | vb;
            4'hA: r = ~vb;
            default: def = 1'b0;
        endcase
        if (def && we) m_regs[d] = r;
        if (def && sc) m_flags = {r[15], (r == 16'h0), c, v};
        e.rd     = d;
        e.data   = r;
        e.regval = m_regs[d];
        e.flg    = m_flags;
        e.cyc    = cyc + 1 + lat;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // in_ready must stay low for k cycles after a shift accept
    task automatic wait_low(input int k);
        for (int j = 0; j < k; j++) begin
            check_eq("ready_low", in_ready, 0);
            @(negedge clk);
        end
        check_eq("ready_high", in_ready, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("drain_timeout", sbq.size(), 0);
        #2;
    endtask

    task automatic reg_is(input string tag, input logic [2:0] r, input logic [15:0] v);
        dbg_addr = r;
        #1;
        check_eq(tag, dbg_data, v);
    endtask

    // Writeback monitor: pop and compare on every retire pulse
    always begin
        @(negedge clk);
        if (!rst && wb_valid) begin
            if (sbq.size() == 0) begin
                check_eq("wb_unexpected", wb_valid, 0);
            end else begin
                mon_e = sbq.pop_front();
                check_eq("wb_rd", wb_rd, mon_e.rd);
                check_eq("wb_data", wb_data, mon_e.data);
                check_eq("wb_cycle", cyc, mon_e.cyc);
                check_eq("flags", flags, mon_e.flg);
                dbg_addr = mon_e.rd;
                #1;
                check_eq("regfile", dbg_data, mon_e.regval);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_rd", wb_rd, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_flags", flags, 0);
        reg_is("rst_r0", 3'd0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // MOVI -1 with flags
        issue(1, 1, 1, 4'h0, 1, 3'd1, 3'd0, 3'd0, 4'hF, 1);
        drain();
        check_eq("t1_flags", flags, 4'b1000);
        reg_is("t1_r1", 3'd1, 16'hFFFF);
        @(negedge clk);

        // Signed overflow on add, zero/no-borrow on sub
        issue(0, 0, 1, 4'h4, 0, 3'd1, 3'd1, 3'd0, 4'h1, 1);
        issue(1, 0, 1, 4'h0, 0, 3'd2, 3'd0, 3'd0, 4'h1, 1);
        issue(0, 0, 0, 4'h0, 1, 3'd3, 3'd1, 3'd2, 4'h0, 1);
        drain();
        reg_is("t2_r3", 3'd3, 16'h8000);
        check_eq("t2_add_flags", flags, 4'b1001);
        @(negedge clk);
        issue(0, 0, 0, 4'h1, 1, 3'd4, 3'd2, 3'd2, 4'h0, 1);
        drain();
        reg_is("t2_r4", 3'd4, 16'h0000);
        check_eq("t2_sub_flags", flags, 4'b0110);
        @(negedge clk);

        // Back-to-back with bypass
        issue(0, 0, 1, 4'h0, 0, 3'd5, 3'd0, 3'd0, 4'h3, 1);
        issue(0, 0, 0, 4'h0, 0, 3'd6, 3'd5, 3'd5, 4'h0, 1);
        drain();
        reg_is("t3_r6", 3'd6, 16'h0006);
        @(negedge clk);

        // Serial shifts with stall
        issue(1, 0, 1, 4'h0, 0, 3'd1, 3'd0, 3'd0, 4'h1, 1);
        issue(0, 0, 1, 4'h6, 1, 3'd1, 3'd1, 3'd0, 4'h1, 1);
        wait_low(1);
        issue(0, 0, 0, 4'h9, 0, 3'd1, 3'd1, 3'd2, 4'h0, 1);
        issue(0, 0, 1, 4'h2, 1, 3'd7, 3'd1, 3'd0, 4'h4, 1);
        wait_low(4);
        drain();
        reg_is("t4_r7", 3'd7, 16'h0010);
        @(negedge clk);

        // Long asr, then shift-by-0 issued while stalled
        issue(1, 0, 1, 4'h0, 0, 3'd1, 3'd0, 3'd0, 4'h1, 1);
        issue(0, 0, 1, 4'h6, 0, 3'd1, 3'd1, 3'd0, 4'h1, 1);
        issue(0, 0, 1, 4'h3, 1, 3'd3, 3'd1, 3'd0, 4'hF, 1);
        issue(0, 0, 1, 4'h4, 1, 3'd4, 3'd3, 3'd0, 4'h0, 1);
        drain();
        reg_is("t5_r3", 3'd3, 16'hFFFF);
        @(negedge clk);

        // Register-sourced rotate, logic ops and undefined opcodes
        issue(0, 0, 0, 4'h5, 1, 3'd5, 3'd1, 3'd2, 4'h0, 1);
        issue(1, 0, 1, 4'h0, 0, 3'd6, 3'd0, 3'd0, 4'hF, 1);
        issue(1, 0, 0, 4'hA, 1, 3'd7, 3'd0, 3'd6, 4'h0, 1);
        issue(0, 0, 0, 4'h8, 1, 3'd5, 3'd7, 3'd3, 4'h0, 1);
        issue(0, 0, 0, 4'hB, 1, 3'd5, 3'd1, 3'd2, 4'h0, 1);
        issue(0, 0, 0, 4'h7, 1, 3'd7, 3'd1, 3'd2, 4'h0, 1);
        drain();
        @(negedge clk);

        // Reset during a shift aborts it
        issue(0, 0, 1, 4'h2, 1, 3'd2, 3'd1, 3'd0, 4'h5, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_in_ready", in_ready, 1);
        check_eq("t6_flags", flags, 0);
        check_eq("t6_wb_valid", wb_valid, 0);
        reg_is("t6_r2", 3'd2, 16'h0000);
        @(negedge clk);
        issue(1, 0, 1, 4'h0, 1, 3'd1, 3'd0, 3'd0, 4'h5, 1);
        issue(0, 0, 0, 4'h0, 0, 3'd3, 3'd1, 3'd1, 4'h0, 0);
        drain();

        for (int i = 0; i < 8; i++) begin
            reg_is("final_reg", 3'(i), m_regs[i]);
        end
        check_eq("final_flags", flags, m_flags);
        check_eq("final_queue", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute/writeback stage directly downstream of the instruction decoder.
- Consumes one decoded instruction per handshake: unary, sgned, imode, aluop, setcc, rD/rA/rB, imm, wben.
- Owns the 8x16 register file and the NZCV flag register.
- Single-cycle ALU for add/sub/logic; serial 1-bit-per-cycle shifter for shl/asr/lsr/rol/ror, which stalls the upstream stage.

Parameters:
- DW, 16, datapath and register width; only the value 16 is supported.
- NREG, 8, register count; register address is 3 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction is present.
- in_ready  out  1  stage can accept an instruction this cycle.
- unary  in  1  operand A is forced to 0 (MOV, NOT).
- sgned  in  1  imm is sign-extended when 1, zero-extended when 0.
- imode  in  1  operand B = extended imm; when 0, B = R[rB].
- aluop  in  4  add 0000, sub 0001, shl 0010, asr 0011, lsr 0100, rol 0101, ror 0110, and 1000, or 1001, not 1010.
- setcc  in  1  update flags at retire.
- rD, rA, rB  in  3 each  destination and source registers.
- imm  in  4  immediate.
- wben  in  1  write the result to R[rD] at retire.
- wb_valid  out  1  one-cycle pulse: an instruction retired this cycle.
- wb_rd  out  3  rD of the retiring instruction.
- wb_data  out  16  result of the retiring instruction.
- flags  out  4  {N,Z,C,V} register.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational R[dbg_addr].

Behaviour:
- Reset:
  - All R[i]=0, flags=0, state=IDLE.
  - in_ready=1, wb_valid=0, wb_rd=0, wb_data=0.
  - Reset during SHIFT aborts the instruction: no write, no flag update.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = (state != SHIFT).
- Operand capture at accept:
  - A = unary ? 0 : R[rA].
  - B = imode ? ext(imm) : R[rB].
  - ext is the sign- or zero-extension of imm to 16 bits, chosen by sgned.
  - Shift amount = B[3:0], unsigned.
- Bypass: if a retire writes register X at the same edge an instruction is accepted, any operand read of X at that accept uses the new value.
- States:
  - IDLE: nothing in flight.
  - EXEC: one instruction completes at the next edge.
  - SHIFT: serial shift in progress; holds acc, cnt, and the last bit shifted out.
- Transitions:
  - From IDLE or EXEC, on accept of a non-shift op, or a shift op with amount 0 -> EXEC.
  - From IDLE or EXEC, on accept of a shift op with amount k>0 -> SHIFT, with cnt=k and acc=A.
  - From EXEC with no accept -> IDLE.
  - SHIFT, each edge: acc shifted 1 bit, cnt decremented.
  - SHIFT, edge where cnt==1: retire, -> IDLE.
- Latency (accept at edge N):
  - Non-shift ops retire at N+1; back-to-back issue at 1 per cycle.
  - Shift by k retires at N+k; in_ready is 0 for k cycles.
  - Shift by 0 retires at N+1 with result=A.
- Results:
  - add: A+B; sub: A+~B+1.
  - and: A&B; or: A|B; not: ~B.
  - MOV is encoded as unary add, so result=B.
  - shl: zero fill at LSB; lsr: zero fill at MSB; asr: replicate bit15.
  - rol/ror: rotate; rotating by 16 is not representable.
- Retire, at the edge:
  - wb_valid=1 for the following cycle; wb_rd=rD; wb_data=result.
  - R[rD]=result if wben.
  - If setcc:
    - N=result[15]; Z=(result==0).
    - add/sub: C=carry-out of bit 15 (sub: C=1 means no borrow); V=signed overflow.
    - Shifts: C=last bit shifted out (0 if amount 0); V=0.
    - Logic: C=0, V=0.
  - If setcc=0: flags unchanged.
- Undefined aluop (0111, 1011–1111): treated as single-cycle; result=0; no register write and no flag update regardless of wben/setcc; wb_valid still pulses.
- wb_data and wb_rd hold their last values when wb_valid=0.

Test Plan:
1. After rst: MOVI (unary, imode, sgned=1, imm=4'hF, rD=1, wben=1, setcc=1) -> edge+1: R1=16'hFFFF, flags N=1 Z=0 C=0 V=0.
2. R1=16'h7FFF, R2=16'h0001; ADD rD=3, rA=1, rB=2, setcc=1 -> R3=16'h8000, N=1 V=1 C=0 Z=0. Then SUB rD=4, rA=2, rB=2 -> R4=0, Z=1 C=1.
3. Back-to-back ADDI R5=R0+3, then ADD R6=R5+R5 on consecutive cycles -> bypass gives R6=6, one retire per cycle.
4. R1=16'h8001; SHLI rA=1, imm=4 -> in_ready low 4 cycles, retire at N+4, result 16'h0010, C=0. RORI imm=1 on 16'h0001 -> 16'h8000, C=1.
5. ASRI on 16'h8000 by 15 -> 16'hFFFF after 15 cycles. LSRI by 0 -> retires at N+1, result unchanged, C=0.
6. Assert rst mid-SHIFT (cnt=3) -> no write to rD, flags unchanged from pre-reset state cleared to 0, in_ready=1 next cycle. setcc=0/wben=0 ADD -> wb_valid pulse only, no state change.
